// File: rtl/ik_div_pkg.sv
// ik_div_pkg: shared constants and types for the inverse-datapath divider arbiter
package ik_div_pkg;
  localparam int WIDTH = 36;
  localparam int LANES = 6;
  localparam logic [WIDTH-1:0] FIXED_ONE = 36'd65536;
  localparam logic [WIDTH-1:0] DIV_SAT = 36'h7_FFFF_FFFF;
  typedef struct packed {
    logic       valid;
    logic [1:0] id;
    logic       divzero;
  } div_tag_t;
  typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;
endpackage

// File: rtl/div_arb_tag_pipe.sv
// div_arb_tag_pipe: resettable shift register carrying requester tags alongside divider operands
module div_arb_tag_pipe import ik_div_pkg::*; #(
  parameter int DEPTH = 7
) (
  input  logic     clk,
  input  logic     reset_n,
  input  div_tag_t tag_in,
  output div_tag_t tag_out,
  output logic     any_valid
);
  div_tag_t [DEPTH-1:0] tags_q, tags_d;
  always_comb tags_d = {tags_q[DEPTH-2:0], tag_in};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tags_q <= '0;
    else tags_q <= tags_d;
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | tags_q[i].valid;
  end
  assign tag_out = tags_q[DEPTH-1];
endmodule

// File: rtl/array_div_arbiter.sv
// array_div_arbiter: shares one pipelined array divider among requesters; ARRAY_DIV_ARB_RR_EN selects round-robin over fixed priority
module array_div_arbiter #(
  parameter int NREQ    = 2,
  parameter int LANES   = 6,
  parameter int WIDTH   = 36,
  parameter int DIV_LAT = 6
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ-1:0][LANES-1:0][WIDTH-1:0] req_dividends,
  input  logic [NREQ-1:0][WIDTH-1:0]          req_divisor,
  output logic [LANES-1:0][WIDTH-1:0]         div_dividends,
  output logic [WIDTH-1:0]                    div_divisor,
  input  logic [LANES-1:0][WIDTH-1:0]         div_quotients,
  output logic [NREQ-1:0]                     rsp_valid,
  output logic [LANES-1:0][WIDTH-1:0]         rsp_quotients,
  output logic                                rsp_divzero,
  output logic                                busy
);
  import ik_div_pkg::*;
  logic [NREQ-1:0] grant;
  logic [1:0] gid;
  logic [LANES-1:0][WIDTH-1:0] div_dividends_q, div_dividends_d, rsp_quotients_q, rsp_quotients_d;
  logic [WIDTH-1:0] div_divisor_q, div_divisor_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic rsp_divzero_q, rsp_divzero_d, pipe_busy;
  div_tag_t tag_in, tag_out;
`ifdef ARRAY_DIV_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  int k;
  // scan from lowest priority up so the entry just after the pointer wins last
  always_comb begin
    grant = '0;
    gid = '0;
    k = 0;
    for (int i = NREQ; i >= 1; i--) begin
      k = (int'(ptr_q) + i) % NREQ;
      if (req_valid[k]) begin
        grant = '0;
        grant[k] = 1'b1;
        gid = 2'(k);
      end
    end
    ptr_d = (|grant) ? gid : ptr_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr_q <= 2'(NREQ-1);
    else ptr_q <= ptr_d;
`else
  always_comb begin
    grant = '0;
    gid = '0;
    for (int i = NREQ-1; i >= 0; i--)
      if (req_valid[i]) begin
        grant = '0;
        grant[i] = 1'b1;
        gid = 2'(i);
      end
  end
`endif
  always_comb begin
    div_dividends_d = '0;
    div_divisor_d = '0;
    tag_in = '0;
    for (int j = 0; j < NREQ; j++)
      if (grant[j]) begin
        div_dividends_d = req_dividends[j];
        div_divisor_d = req_divisor[j];
      end
    tag_in.valid = |grant;
    tag_in.id = gid;
    tag_in.divzero = (|grant) && (div_divisor_d == '0);
  end
  div_arb_tag_pipe #(.DEPTH(DIV_LAT+1)) u_tags (
    .clk(clk), .reset_n(reset_n), .tag_in(tag_in), .tag_out(tag_out), .any_valid(pipe_busy)
  );
  always_comb begin
    rsp_valid_d = '0;
    for (int j = 0; j < NREQ; j++) rsp_valid_d[j] = tag_out.valid && (tag_out.id == 2'(j));
    rsp_divzero_d = tag_out.valid && tag_out.divzero;
    rsp_quotients_d = !tag_out.valid ? '0 : tag_out.divzero ? {LANES{WIDTH'(DIV_SAT)}} : div_quotients;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div_dividends_q <= '0;
      div_divisor_q <= '0;
      rsp_valid_q <= '0;
      rsp_quotients_q <= '0;
      rsp_divzero_q <= 1'b0;
    end else begin
      div_dividends_q <= div_dividends_d;
      div_divisor_q <= div_divisor_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_quotients_q <= rsp_quotients_d;
      rsp_divzero_q <= rsp_divzero_d;
    end
  assign req_ready = grant;
  assign div_dividends = div_dividends_q;
  assign div_divisor = div_divisor_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_quotients = rsp_quotients_q;
  assign rsp_divzero = rsp_divzero_q;
  assign busy = pipe_busy | (|rsp_valid_q);
endmodule

// File: tb/tb_array_div_arbiter.sv
// tb_array_div_arbiter: randomized and directed checks of the divider arbiter against a scoreboard model
module tb_array_div_arbiter;
  localparam int NREQ = 2, LANES = 6, WIDTH = 36, DIV_LAT = 6, LAT = DIV_LAT + 2;
  localparam logic [WIDTH-1:0] SAT = 36'h7_FFFF_FFFF;
  typedef logic [LANES-1:0][WIDTH-1:0] lanes_v;
  typedef struct {
    int     cyc;
    int     id;
    logic   dz;
    lanes_v q;
  } rsp_t;
  logic clk = 1'b0, reset_n = 1'b1;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  logic [NREQ-1:0][LANES-1:0][WIDTH-1:0] req_dividends;
  logic [NREQ-1:0][WIDTH-1:0] req_divisor;
  lanes_v div_dividends, div_quotients, rsp_quotients;
  logic [WIDTH-1:0] div_divisor;
  logic rsp_divzero, busy;
  array_div_arbiter #(.NREQ(NREQ), .LANES(LANES), .WIDTH(WIDTH), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividends(req_dividends), .req_divisor(req_divisor), .div_dividends(div_dividends),
    .div_divisor(div_divisor), .div_quotients(div_quotients), .rsp_valid(rsp_valid),
    .rsp_quotients(rsp_quotients), .rsp_divzero(rsp_divzero), .busy(busy)
  );
  always #5 clk = ~clk;
  // fixed-point quotient, 1.0 = 65536; a zero divisor yields junk the arbiter must hide
  function automatic logic [WIDTH-1:0] fx_div(logic [WIDTH-1:0] n, logic [WIDTH-1:0] d);
    longint a, b;
    a = $signed(n);
    b = $signed(d);
    return (b == 0) ? 36'h0_DEAD_BEEF : WIDTH'((a * 65536) / b);
  endfunction
  lanes_v dpipe [DIV_LAT];
  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++) dpipe[0][l] <= fx_div(div_dividends[l], div_divisor);
    for (int i = 1; i < DIV_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_quotients = dpipe[DIV_LAT-1];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, ptr = NREQ - 1, last_hs = -100, last_g = -1, n_rsp = 0, n0;
  rsp_t exq[$];
  int grant_log[$];
  lanes_v exp_div = '0, last_q;
  logic [WIDTH-1:0] exp_dvs = '0;
  logic [NREQ-1:0] last_rv;
  logic last_dz;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    int g;
    rsp_t r;
    @(negedge clk);
    g = -1;
    for (int i = 1; i <= NREQ; i++) begin
      int k;
`ifdef ARRAY_DIV_ARB_RR_EN
      k = (ptr + i) % NREQ;
`else
      k = i - 1;
`endif
      if (g < 0 && req_valid[k]) g = k;
    end
    chk("req_ready", 64'(req_ready), g < 0 ? 64'd0 : 64'd1 << g);
    chk("div_divisor", 64'(div_divisor), 64'(exp_dvs));
    for (int l = 0; l < LANES; l++) chk("div_dividend", 64'(div_dividends[l]), 64'(exp_div[l]));
    last_rv = rsp_valid;
    last_q = rsp_quotients;
    last_dz = rsp_divzero;
    if (rsp_valid != 0) n_rsp++;
    if (exq.size() != 0 && exq[0].cyc == cyc) begin
      r = exq.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'd1 << r.id);
      chk("rsp_divzero", 64'(rsp_divzero), 64'(r.dz));
      for (int l = 0; l < LANES; l++) chk("rsp_quot", 64'(rsp_quotients[l]), 64'(r.q[l]));
    end else begin
      chk("rsp_idle_valid", 64'(rsp_valid), 64'd0);
      chk("rsp_idle_dz", 64'(rsp_divzero), 64'd0);
      for (int l = 0; l < LANES; l++) chk("rsp_idle_quot", 64'(rsp_quotients[l]), 64'd0);
    end
    chk("busy", 64'(busy), 64'(cyc - last_hs >= 1 && cyc - last_hs <= LAT));
    last_g = g;
    if (g >= 0) begin
      r.cyc = cyc + LAT;
      r.id = g;
      r.dz = (req_divisor[g] == 0);
      for (int l = 0; l < LANES; l++) r.q[l] = r.dz ? SAT : fx_div(req_dividends[g][l], req_divisor[g]);
      exq.push_back(r);
      exp_div = req_dividends[g];
      exp_dvs = req_divisor[g];
      last_hs = cyc;
      ptr = g;
      grant_log.push_back(g);
    end else begin
      exp_div = '0;
      exp_dvs = '0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic do_reset();
    req_valid = '0;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    exq.delete();
    last_hs = -100;
    ptr = NREQ - 1;
    exp_div = '0;
    exp_dvs = '0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1 reset_n = 1'b1;
  endtask
  function automatic logic [WIDTH-1:0] rnd_val(int mag);
    int v;
    v = int'($urandom_range(0, mag));
    return $urandom_range(0, 1) ? WIDTH'(-v) : WIDTH'(v);
  endfunction
  task automatic load(int k);
    req_valid[k] = 1'b1;
    req_divisor[k] = ($urandom_range(0, 7) == 0) ? '0 : rnd_val(1 << 20) | 36'd1;
    for (int l = 0; l < LANES; l++) req_dividends[k][l] = rnd_val(1 << 18);
  endtask
  task automatic rand_drive();
    for (int k = 0; k < NREQ; k++)
      if (!req_valid[k] || last_g == k) begin
        if ($urandom_range(0, 1) == 1) load(k);
        else req_valid[k] = 1'b0;
      end else if ($urandom_range(0, 7) == 0) req_valid[k] = 1'b0;
  endtask
  initial begin
    req_valid = '0;
    req_dividends = '0;
    req_divisor = '0;
    #2 do_reset();
    grant_log.delete();
    load(0);
    load(1);
    req_divisor[0] = 36'd65536;
    req_divisor[1] = 36'd196608;
    repeat (4) tick();
    req_valid = '0;
    for (int i = 0; i < 4; i++)
`ifdef ARRAY_DIV_ARB_RR_EN
      chk("cont_grant", 64'(grant_log[i]), 64'(i % 2));
`else
      chk("cont_grant", 64'(grant_log[i]), 64'd0);
`endif
    repeat (10) tick();
    req_dividends[0] = '0;
    req_dividends[0][0] = 36'd65536;
    req_divisor[0] = 36'd131072;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    repeat (8) tick();
    chk("single_valid", 64'(last_rv), 64'd1);
    chk("single_q0", 64'(last_q[0]), 64'd32768);
    load(1);
    req_divisor[1] = '0;
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    repeat (8) tick();
    chk("dz_valid", 64'(last_rv), 64'd2);
    chk("dz_flag", 64'(last_dz), 64'd1);
    chk("dz_q0", 64'(last_q[0]), 64'(SAT));
    chk("dz_q5", 64'(last_q[LANES-1]), 64'(SAT));
    n0 = n_rsp;
    for (int i = 0; i < 6; i++) begin
      load(0);
      req_divisor[0] = 36'(65536 * (i + 1));
      req_valid = 2'b01;
      tick();
    end
    req_valid = '0;
    repeat (10) tick();
    chk("burst_cnt", 64'(n_rsp - n0), 64'd6);
    load(0);
    req_valid = 2'b01;
    tick();
    load(1);
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    repeat (3) tick();
    do_reset();
    n0 = n_rsp;
    repeat (12) tick();
    chk("rst_no_rsp", 64'(n_rsp - n0), 64'd0);
    load(0);
    load(1);
    tick();
    chk("rst_next_grant", 64'(last_g), 64'd0);
    req_valid = '0;
    repeat (10) tick();
    n0 = n_rsp;
    repeat (20) tick();
    chk("idle_no_rsp", 64'(n_rsp - n0), 64'd0);
    repeat (400) begin
      tick();
      rand_drive();
    end
    req_valid = '0;
    repeat (12) tick();
    chk("scoreboard_empty", 64'(exq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/array_div_arbiter.md
# array_div_arbiter

Shares the single 6-lane, 36-bit pipelined array divider in the inverse datapath between several requesters, such as the lower-triangular inverse sequencer and the Cholesky square-root/normalise stage. Each cycle it grants at most one request and drives the divider operands from registers. It carries a requester tag alongside every in-flight operation and returns the registered quotients, with a divide-by-zero flag, to the requester that issued them. It sits between the requester blocks and the shared divider instance.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..4).
- LANES, 6: dividend/quotient lanes per operation.
- WIDTH, 36: operand width, two's-complement fixed point, 1.0 = 65536.
- DIV_LAT, 6: divider latency, in cycles, from operands present to quotients valid.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot grant (combinational); a handshake occurs when req_valid[k] & req_ready[k].
- req_dividends  in  NREQ x LANES x WIDTH  dividends per requester.
- req_divisor  in  NREQ x WIDTH  common divisor per requester.
- div_dividends  out  LANES x WIDTH  registered operands to the divider.
- div_divisor  out  WIDTH  registered divisor to the divider.
- div_quotients  in  LANES x WIDTH  divider result, DIV_LAT cycles after operands.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse; the response belongs to requester k.
- rsp_quotients  out  LANES x WIDTH  shared response bus.
- rsp_divzero  out  1  the response's divisor was zero.
- busy  out  1  at least one operation is in flight.

## Operation
- Arbitration: req_ready is a one-hot selection among the asserted req_valid bits. req_ready is all-zero when no requester is valid. req_ready depends only on req_valid and the priority state, never on data.
- Issue: on a handshake, register the requester's dividends and divisor into div_*. Push tag {valid=1, id=k, divzero=(divisor==0)} into the tag pipeline.
- Idle cycle (no handshake): div_dividends and div_divisor are driven to zero, and a tag with valid=0 is pushed.
- Tag pipeline: DIV_LAT+1 stages deep, so each tag stays aligned with its operands as they pass through the divider.
- Response: when the tag exits the pipeline, register div_quotients into rsp_quotients, pulse rsp_valid[id] and set rsp_divzero.
- Divide-by-zero: when divzero=1, every rsp_quotients lane is forced to 36'h7_FFFF_FFFF and the divider output is ignored.
- Non-valid exit: rsp_valid stays all-zero and rsp_quotients is driven to zero.
- busy: OR of all tag valid bits plus the output stage.
- Throughput: one operation per cycle; there is no back-pressure on responses, so requesters must accept them.

## Timing
- Handshake at cycle t: div_* valid during cycle t+1, and rsp_valid during cycle t+2+DIV_LAT. The default latency is 8 cycles.
- Back-to-back grants in consecutive cycles produce responses in consecutive cycles, in issue order.
- A requester holding req_valid high keeps its data stable until it sees req_ready. Deasserting req_valid before a grant is permitted.
- Reset values: div_dividends, div_divisor and rsp_quotients are 0; rsp_valid is 0; rsp_divzero is 0; busy is 0; all tags are invalid; the round-robin pointer points to requester NREQ-1, so requester 0 has highest priority first.
- Reset mid-operation: all in-flight tags are cleared immediately. No rsp_valid is issued for operations in flight when reset was asserted.
- Simultaneous grant and response in the same cycle are independent and both occur.

## Configuration
- ARRAY_DIV_ARB_RR_EN defined: round-robin arbitration. After a grant to k, priority order becomes k+1, k+2, …, wrapping modulo NREQ. The pointer updates only on a handshake.
- ARRAY_DIV_ARB_RR_EN not defined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Shared package ik_div_pkg holds:
  - the constants WIDTH, LANES and FIXED_ONE (36'd65536) and the saturation constant DIV_SAT (36'h7_FFFF_FFFF);
  - the typedef div_tag_t {valid, id, divzero};
  - the typedef lanes_t, a packed LANES x WIDTH array.
- One sub-module, div_arb_tag_pipe: a parameterised depth, resettable shift register of div_tag_t. The arbiter, operand registers and response stage stay in array_div_arbiter.

## Test plan
- Single request: r0 sends dividends {65536, 0, …} with divisor 131072 -> 8 cycles later rsp_valid=2'b01 and lane0 quotient = 32768.
- Contention: r0 and r1 both request for 4 cycles.
  - With RR: grants alternate 0,1,0,1 and responses return in the same order with matching ids.
  - Without RR: r0 is granted every cycle.
- Divide-by-zero: r1 sends divisor 0 -> rsp_valid=2'b10, rsp_divzero=1 and all lanes = 36'h7_FFFF_FFFF, regardless of div_quotients.
- Pipelined burst: 6 back-to-back grants with distinct divisors -> 6 consecutive responses in order, and busy stays high from t+1 through the last response.
- Reset mid-flight: assert reset_n=0 three cycles after two grants -> no rsp_valid after release, busy=0, and the next grant goes to requester 0.
- Idle: no req_valid for 20 cycles -> div_* = 0, rsp_valid = 0 and busy = 0 throughout.
